// File: rtl/leds7_multi_control_pkg.sv
// Shared definitions for the seven-segment command controller family.
// Contents:
//   bin_to_led7      hex nibble -> active-high segment pattern {g,f,e,d,c,b,a}
//   LED7_HDR_*       header nibbles for single and burst writes
//   LED7_CMD_CLEAR   full-byte clear-all command
//   led7_fsm_t       command parser states
//   led7_digit_t     stored per-digit state (blank flag + hex value)
package Leds_7_pkg;

    localparam logic [3:0] LED7_HDR_SINGLE = 4'hF;
    localparam logic [3:0] LED7_HDR_BURST  = 4'hE;
    localparam logic [7:0] LED7_CMD_CLEAR  = 8'hD0;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SINGLE_DATA = 2'd1,
        BURST_COUNT = 2'd2,
        BURST_DATA  = 2'd3
    } led7_fsm_t;

    typedef struct packed {
        logic       blank;
        logic [3:0] value;
    } led7_digit_t;

    // Active-high pattern; callers invert it for the active-low drivers.
    function automatic logic [6:0] bin_to_led7(input logic [3:0] bin);
        logic [6:0] seg;
        case (bin)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/leds7_cmd_timer.sv
// Inter-byte timeout for an in-progress command.
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   clear        a byte was consumed this cycle; reload the counter
//   enable       a command is in progress; count idle cycles
//   expire       high in the cycle the idle limit is reached (combinational)
// With TIMEOUT_CYCLES = 0 the timer is absent and expire is tied low.
module leds7_cmd_timer
    import Leds_7_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, resetn, clear, enable};
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] remaining;

            // Down-counter: holds the number of idle cycles still allowed,
            // including the current one. Idle (disabled) keeps it reloaded.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    remaining <= LOAD;
                end else if (clear || !enable) begin
                    remaining <= LOAD;
                end else if (remaining != '0) begin
                    remaining <= remaining - CW'(1);
                end
            end

            // A byte in the terminal cycle takes priority, so mask with clear.
            assign expire = enable && !clear && (remaining == CW'(1));
        end
    endgenerate

endmodule

// File: rtl/leds7_multi_control.sv
// UART byte-stream decoder driving N_LEDS seven-segment digits.
// Ports:
//   clk, resetn       clock and synchronous active-low reset
//   uart_data         received byte, qualified by uart_data_valid
//   uart_data_valid   one-cycle strobe; one byte consumed per strobe
//   leds_data         per-digit active-low segments (7'h7F = dark)
//   led_data_valid    one-cycle pulse per digit written
//   cmd_busy          high while a command is incomplete
//   cmd_error         one-cycle pulse on protocol error or timeout
//
// state        | meaning
// -------------+----------------------------------------------------
// IDLE         | waiting for a header byte (F0+k, E0+k, D0)
// SINGLE_DATA  | next byte is the data for digit 'target'
// BURST_COUNT  | next byte is the burst length (1..N_LEDS)
// BURST_DATA   | 'remaining' data bytes go to digits ptr, ptr+1, ... (wrapping)
module leds7_multi_control
    import Leds_7_pkg::*;
#(
    parameter int unsigned N_LEDS         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             uart_data,
    input  logic                   uart_data_valid,
    output logic [N_LEDS-1:0][6:0] leds_data,
    output logic [N_LEDS-1:0]      led_data_valid,
    output logic                   cmd_busy,
    output logic                   cmd_error
);

    localparam int IW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    localparam logic [1:0] ST_IDLE        = 2'(IDLE);
    localparam logic [1:0] ST_SINGLE_DATA = 2'(SINGLE_DATA);
    localparam logic [1:0] ST_BURST_COUNT = 2'(BURST_COUNT);
    localparam logic [1:0] ST_BURST_DATA  = 2'(BURST_DATA);

    logic [1:0]    state;
    logic [IW-1:0] target;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;
    logic [4:0]    remaining;
    led7_digit_t   digits [N_LEDS];

    logic [3:0]    hdr;
    logic [3:0]    nib;
    logic [IW-1:0] nib_idx;
    logic          nib_in_range;
    logic          count_ok;
    led7_digit_t   wr_digit;
    logic          expire;

    assign hdr      = uart_data[7:4];
    assign nib      = uart_data[3:0];
    assign nib_idx  = nib[IW-1:0];
    // Full 4-bit compare so any header index >= N_LEDS is rejected,
    // not silently truncated into range.
    assign nib_in_range = (32'(nib) < N_LEDS);
    assign count_ok     = (uart_data != 8'd0) && (32'(uart_data) <= N_LEDS);
    assign wr_digit     = '{blank: uart_data[4], value: uart_data[3:0]};
    assign ptr_next     = (ptr == IW'(N_LEDS - 1)) ? '0 : ptr + IW'(1);

    assign cmd_busy = (state != ST_IDLE);

    leds7_cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_cmd_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (uart_data_valid),
        .enable (cmd_busy),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            target         <= '0;
            ptr            <= '0;
            remaining      <= '0;
            led_data_valid <= '0;
            cmd_error      <= 1'b0;
            for (int i = 0; i < N_LEDS; i++) begin
                digits[i] <= '{blank: 1'b1, value: 4'h0};
            end
        end else begin
            led_data_valid <= '0;
            cmd_error      <= 1'b0;

            if (uart_data_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (hdr == LED7_HDR_SINGLE && nib_in_range) begin
                            state  <= ST_SINGLE_DATA;
                            target <= nib_idx;
                        end else if (hdr == LED7_HDR_BURST && nib_in_range) begin
                            state <= ST_BURST_COUNT;
                            ptr   <= nib_idx;
                        end else if (uart_data == LED7_CMD_CLEAR) begin
                            // Values are kept; only the blank flags are set.
                            for (int i = 0; i < N_LEDS; i++) begin
                                digits[i].blank <= 1'b1;
                            end
                            led_data_valid <= '1;
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end

                    ST_SINGLE_DATA: begin
                        digits[target]         <= wr_digit;
                        led_data_valid[target] <= 1'b1;
                        state                  <= ST_IDLE;
                    end

                    ST_BURST_COUNT: begin
                        if (count_ok) begin
                            remaining <= uart_data[4:0];
                            state     <= ST_BURST_DATA;
                        end else begin
                            cmd_error <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end

                    ST_BURST_DATA: begin
                        digits[ptr]         <= wr_digit;
                        led_data_valid[ptr] <= 1'b1;
                        ptr                 <= ptr_next;
                        remaining           <= remaining - 5'd1;
                        if (remaining == 5'd1) begin
                            state <= ST_IDLE;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end else if (expire) begin
                // Digits already written by a partial burst are kept.
                state     <= ST_IDLE;
                cmd_error <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            leds_data[i] = digits[i].blank ? 7'h7F : ~bin_to_led7(digits[i].value);
        end
    end

endmodule

// File: tb/tb_leds7_multi_control.sv
module tb_leds7_multi_control;

    localparam int N = 4;
    localparam int T = 100;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic [7:0]          uart_data = 8'h00;
    logic                uart_data_valid = 1'b0;
    logic [N-1:0][6:0]   leds_data;
    logic [N-1:0]        led_data_valid;
    logic                cmd_busy;
    logic                cmd_error;

    always #5 clk = ~clk;

    leds7_multi_control #(
        .N_LEDS(N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .uart_data       (uart_data),
        .uart_data_valid (uart_data_valid),
        .leds_data       (leds_data),
        .led_data_valid  (led_data_valid),
        .cmd_busy        (cmd_busy),
        .cmd_error       (cmd_error)
    );

    typedef struct {
        logic [N-1:0]      vmask;
        logic              err;
        logic [N-1:0][6:0] leds;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: digit contents plus a list of digits still owed data.
    int   mval[N];
    bit   mblank[N];
    int   tgt_q[$];
    bit   await_cnt;
    int   burst_k;
    int   gap;

    // Active-high hex segment patterns {g,f,e,d,c,b,a}.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [N-1:0][6:0] snapshot();
        logic [N-1:0][6:0] s;
        for (int i = 0; i < N; i++) s[i] = mblank[i] ? 7'h7F : ~seg_tab[mval[i]];
        return s;
    endfunction

    function automatic bit model_busy();
        return (tgt_q.size() > 0) || await_cnt;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] vm, input logic er);
        exp_t e;
        e.vmask = vm;
        e.err   = er;
        e.leds  = snapshot();
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mval[i]   = 0;
            mblank[i] = 1'b1;
        end
        tgt_q.delete();
        await_cnt = 1'b0;
        burst_k   = 0;
        gap       = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int idx;
        if (tgt_q.size() > 0) begin
            idx         = tgt_q.pop_front();
            mval[idx]   = int'(b[3:0]);
            mblank[idx] = b[4];
            push_exp(N'(1) << idx, 1'b0);
        end else if (await_cnt) begin
            await_cnt = 1'b0;
            if (int'(b) >= 1 && int'(b) <= N) begin
                for (int j = 0; j < int'(b); j++) tgt_q.push_back((burst_k + j) % N);
            end else begin
                push_exp('0, 1'b1);
            end
        end else if (b[7:4] == 4'hF && int'(b[3:0]) < N) begin
            tgt_q.push_back(int'(b[3:0]));
        end else if (b[7:4] == 4'hE && int'(b[3:0]) < N) begin
            await_cnt = 1'b1;
            burst_k   = int'(b[3:0]);
        end else if (b == 8'hD0) begin
            for (int i = 0; i < N; i++) mblank[i] = 1'b1;
            push_exp('1, 1'b0);
        end else begin
            push_exp('0, 1'b1);
        end
    endtask

    // One clock cycle of stimulus; inputs change on the falling edge.
    task automatic drive(input bit v, input logic [7:0] d);
        uart_data_valid = v;
        uart_data       = d;
        if (v) begin
            model_byte(d);
            gap = 0;
        end else if (model_busy()) begin
            gap++;
            if (gap == T) begin
                push_exp('0, 1'b1);
                tgt_q.delete();
                await_cnt = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        uart_data_valid = 1'b0;
        check("cmd_busy", 64'(cmd_busy), 64'(model_busy()));
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic pulse_reset();
        uart_data_valid = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        check("busy_after_reset", 64'(cmd_busy), 64'd0);
        check("leds_after_reset", 64'(leds_data), 64'(snapshot()));
    endtask

    // Monitor: every output event must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && (led_data_valid !== '0 || cmd_error !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got valid=%b err=%b expected no event at %0t",
                         led_data_valid, cmd_error, $time);
            end else begin
                e = exp_q.pop_front();
                check("valid_mask", 64'(led_data_valid), 64'(e.vmask));
                check("cmd_error", 64'(cmd_error), 64'(e.err));
                check("leds_data", 64'(leds_data), 64'(e.leds));
            end
        end
    end

    initial begin
        logic [7:0] b;
        int         sel;
        int         g;

        model_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;
        check("reset_leds", 64'(leds_data), 64'h0FFF_FFFF);
        check("reset_valid", 64'(led_data_valid), 64'd0);
        check("reset_busy", 64'(cmd_busy), 64'd0);
        check("reset_error", 64'(cmd_error), 64'd0);
        idle(3);

        // Single write.
        send(8'hF2); send(8'h05);
        idle(2);
        // Back-to-back burst with wrap and a blanked digit.
        send(8'hE3); send(8'h03); send(8'h01); send(8'h02); send(8'h13);
        idle(2);
        // Bad index, zero count, unknown byte.
        send(8'hF7); idle(1);
        send(8'hE1); send(8'h00); idle(1);
        send(8'h42); idle(2);
        // Timeout mid-burst, then a fresh header is accepted.
        send(8'hE0); send(8'h04); send(8'h0A);
        idle(T);
        send(8'hF1); send(8'h07);
        idle(2);
        // Byte arriving in the terminal cycle wins.
        send(8'hE0); send(8'h04); send(8'h0A);
        idle(T - 1);
        send(8'h0B); send(8'h0C); send(8'h0D);
        idle(2);
        // Header value used as data.
        send(8'hF3); send(8'hF0);
        idle(2);
        // Reset mid-burst aborts silently; then clear-all.
        send(8'hE1); send(8'h02); send(8'h05);
        idle(2);
        pulse_reset();
        send(8'hD0);
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    b = {4'hF, 4'($urandom_range(0, 5))};
                2, 3:    b = {4'hE, 4'($urandom_range(0, 5))};
                4:       b = 8'($urandom_range(0, 6));
                5:       b = 8'hD0;
                default: b = 8'($urandom);
            endcase
            if ($urandom_range(0, 24) == 0)      g = int'($urandom_range(T - 2, T + 2));
            else if ($urandom_range(0, 3) == 0)  g = int'($urandom_range(1, 5));
            else                                 g = 0;
            idle(g);
            send(b);
        end

        idle(T + 10);
        check("pending_events", 64'(exp_q.size()), 64'd0);
        check("final_leds", 64'(leds_data), 64'(snapshot()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
